// File: rtl/pixel_frame_buffer.sv
// Ping-pong frame buffer between the dual-channel ADC capture and the SPI/USB output stage.
// Define FRAME_CHECKSUM_EN to build the per-frame word-sum accumulator that drives frame_sum.
module pixel_frame_buffer #(
  parameter int PIXELS_PER_CH = 128,
  parameter int DATA_W        = 12,
  parameter int ADDR_W        = 8
) (
  input  logic                     clk_20M,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic                     new_Data,
  input  logic [DATA_W-1:0]        Data1,
  input  logic [DATA_W-1:0]        Data2,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     frame_ready,
  output logic [7:0]               frame_count,
  output logic                     overrun,
  output logic [DATA_W+ADDR_W-1:0] frame_sum
);

  localparam int WORDS = 2 * PIXELS_PER_CH;
  localparam int SUM_W = DATA_W + ADDR_W;

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_COMMIT} wstate_t;
  typedef enum logic       {R_IDLE, R_ACTIVE}         rstate_t;

  typedef struct packed {
    logic              en;
    logic [ADDR_W:0]   addr;   // {bank, word}
    logic [DATA_W-1:0] data;
  } wr_req_t;

  logic [DATA_W-1:0] mem [0:2**(ADDR_W+1)-1];

  wstate_t           w_state, w_next;
  rstate_t           r_state, r_next;
  logic              wr_bank, rd_full;
  logic [ADDR_W-1:0] idx, ptr;
  logic              d2_pend;
  logic [DATA_W-1:0] d2_lat;

  wr_req_t wr;
  logic    idx_clr, idx_inc, d2_cap, abort, commit_ok, commit_drop;
  logic    rd_issue, rd_release;

  // ---------------- write FSM ----------------
  always_ff @(posedge clk_20M) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:   if (frame_start) w_next = W_FILL;
      W_FILL:   if (!frame_start && d2_pend && idx == ADDR_W'(PIXELS_PER_CH - 1))
                  w_next = W_COMMIT;
      W_COMMIT: w_next = W_IDLE;
      default:  w_next = W_IDLE;
    endcase
  end

  // Data1 goes in on the strobe cycle; the latched Data2 follows one cycle later.
  always_comb begin
    wr          = '0;
    idx_clr     = 1'b0;
    idx_inc     = 1'b0;
    d2_cap      = 1'b0;
    abort       = 1'b0;
    commit_ok   = 1'b0;
    commit_drop = 1'b0;
    case (w_state)
      W_IDLE: idx_clr = frame_start;
      W_FILL: begin
        if (frame_start) begin
          abort   = 1'b1;
          idx_clr = 1'b1;
        end else if (d2_pend) begin
          wr.en   = 1'b1;
          wr.addr = {wr_bank, idx[ADDR_W-2:0], 1'b1};
          wr.data = d2_lat;
          idx_inc = 1'b1;
        end else if (new_Data) begin
          wr.en   = 1'b1;
          wr.addr = {wr_bank, idx[ADDR_W-2:0], 1'b0};
          wr.data = Data1;
          d2_cap  = 1'b1;
        end
      end
      // A release in the same cycle frees the read bank, so the commit still lands.
      W_COMMIT: begin
        if (!rd_full || rd_release) commit_ok   = 1'b1;
        else                        commit_drop = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_20M) begin
    if (wr.en) mem[wr.addr] <= wr.data;
  end

  always_ff @(posedge clk_20M) begin
    if (reset) begin
      idx         <= '0;
      d2_pend     <= 1'b0;
      d2_lat      <= '0;
      wr_bank     <= 1'b0;
      rd_full     <= 1'b0;
      frame_count <= '0;
      overrun     <= 1'b0;
    end else begin
      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= idx + 1'b1;
      d2_pend <= d2_cap;
      if (d2_cap) d2_lat <= Data2;
      if (abort || commit_drop) overrun <= 1'b1;
      if (commit_ok) begin
        wr_bank     <= ~wr_bank;
        frame_count <= frame_count + 8'd1;
      end
      if (commit_ok)       rd_full <= 1'b1;
      else if (rd_release) rd_full <= 1'b0;
    end
  end

  assign frame_ready = rd_full;

  // ---------------- read FSM ----------------
  always_ff @(posedge clk_20M) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:   if (rd_issue && !rd_release) r_next = R_ACTIVE;
      R_ACTIVE: if (rd_release) r_next = R_IDLE;
      default:  r_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_issue = 1'b0;
    case (r_state)
      R_IDLE:   rd_issue = rd_en && rd_full;
      R_ACTIVE: rd_issue = rd_en;
      default:  rd_issue = 1'b0;
    endcase
    rd_release = rd_issue && (ptr == ADDR_W'(WORDS - 1));
  end

  always_ff @(posedge clk_20M) begin
    if (reset) begin
      ptr      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (rd_release)    ptr <= '0;
      else if (rd_issue) ptr <= ptr + 1'b1;
      if (rd_issue) rd_data <= mem[{~wr_bank, ptr}];
      rd_valid <= rd_issue;
    end
  end

  // ---------------- checksum ----------------
`ifdef FRAME_CHECKSUM_EN
  logic [SUM_W-1:0] acc, sum_q;

  always_ff @(posedge clk_20M) begin
    if (reset) begin
      acc   <= '0;
      sum_q <= '0;
    end else begin
      if (idx_clr)    acc <= '0;
      else if (wr.en) acc <= acc + SUM_W'(wr.data);
      if (commit_ok) sum_q <= acc;
    end
  end

  assign frame_sum = sum_q;
`else
  assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Directed bench for pixel_frame_buffer: expected read words go into a scoreboard queue,
// a negedge monitor pops and checks them against rd_data and the cycle they must appear in.
module tb_pixel_frame_buffer;

  logic        clk_20M = 1'b0;
  logic        reset, frame_start, new_Data, rd_en;
  logic [11:0] Data1, Data2, rd_data;
  logic        rd_valid, frame_ready, overrun;
  logic [7:0]  frame_count;
  logic [19:0] frame_sum;

`ifdef FRAME_CHECKSUM_EN
  localparam logic [19:0] SUM0 = 20'h7FF80;  // 128 * 0xFFF
  localparam logic [19:0] SUM1 = 20'h4BF80;  // 128*0x900 + 2*(0+..+127)
  localparam logic [19:0] SUM2 = 20'hFFF00;  // 256 * 0xFFF
`else
  localparam logic [19:0] SUM0 = 20'h0;
  localparam logic [19:0] SUM1 = 20'h0;
  localparam logic [19:0] SUM2 = 20'h0;
`endif

  pixel_frame_buffer dut (
    .clk_20M(clk_20M), .reset(reset), .frame_start(frame_start), .new_Data(new_Data),
    .Data1(Data1), .Data2(Data2), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .frame_ready(frame_ready), .frame_count(frame_count), .overrun(overrun),
    .frame_sum(frame_sum)
  );

  always #25 clk_20M = ~clk_20M;

  typedef struct {
    logic [11:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cmp_cnt = 0, err_cnt = 0, cyc = 0;

  always @(posedge clk_20M) cyc <= cyc + 1;

  always @(negedge clk_20M) begin
    exp_t e;
    if (rd_valid) begin
      cmp_cnt++;
      if (sb.size() == 0) begin
        err_cnt++;
        $display("FAIL rd_valid_unexpected: got data=%h at cycle %0d, required no rd_valid", rd_data, cyc);
      end else begin
        e = sb.pop_front();
        if (rd_data !== e.data || cyc != e.cyc) begin
          err_cnt++;
          $display("FAIL rd_word: got %h at cycle %0d, required %h at cycle %0d", rd_data, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_20M); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_frame_ready"}, 32'(frame_ready), 0);
    check({tag, "_frame_count"}, 32'(frame_count), 0);
    check({tag, "_overrun"},     32'(overrun), 0);
    check({tag, "_rd_valid"},    32'(rd_valid), 0);
    check({tag, "_rd_data"},     32'(rd_data), 0);
    check({tag, "_frame_sum"},   32'(frame_sum), 0);
  endtask

  // sel 0: D1=i, D2=0xFFF-i; sel 1: D1=0x800+i, D2=0x100+i; sel 2: all 0xFFF
  function automatic logic [11:0] pat(input int sel, input int w);
    logic [11:0] iv;
    iv = 12'(w / 2);
    case (sel)
      0:       return w[0] ? 12'hFFF - iv : iv;
      1:       return w[0] ? 12'h100 + iv : 12'h800 + iv;
      default: return 12'hFFF;
    endcase
  endfunction

  task automatic do_reset;
    reset = 1'b1; tick; tick; reset = 1'b0;
  endtask

  // Returns one cycle after the last strobe was sampled.
  task automatic frame(input int sel, input int n);
    frame_start = 1'b1; tick; frame_start = 1'b0; tick;
    for (int i = 0; i < n; i++) begin
      Data1 = pat(sel, 2*i); Data2 = pat(sel, 2*i+1); new_Data = 1'b1;
      tick;
      new_Data = 1'b0; Data1 = 12'h5A5; Data2 = 12'hA5A;
      if (i != n-1) repeat (3) tick;
    end
  endtask

  task automatic read_stream(input int n, input int sel, input int nexp);
    for (int k = 0; k < n; k++) begin
      rd_en = 1'b1;
      if (k < nexp) sb.push_back('{pat(sel, k), cyc + 1});
      tick;
    end
    rd_en = 1'b0;
    for (int t = 0; t < 10 && sb.size() != 0; t++) tick;
    check("sb_drain", 32'(sb.size()), 0);
    sb.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; frame_start = 1'b0; new_Data = 1'b0; rd_en = 1'b0;
    Data1 = '0; Data2 = '0;
    tick; tick;
    @(negedge clk_20M);
    check_all_zero("reset");
    reset = 1'b0; tick;

    // basic capture, 3-cycle latency, full streamed readout
    frame(0, 128);
    @(negedge clk_20M); check("lat_c1", 32'(frame_ready), 0);
    @(negedge clk_20M); check("lat_c2", 32'(frame_ready), 0);
    @(negedge clk_20M); check("lat_c3", 32'(frame_ready), 1);
    check("t1_count", 32'(frame_count), 1);
    check("t1_overrun", 32'(overrun), 0);
    check("t1_sum", 32'(frame_sum), 32'(SUM0));
    tick;
    read_stream(256, 0, 256);
    check("t1_ready_after_read", 32'(frame_ready), 0);

    // rd_en with no frame ready: no rd_valid, rd_data holds last word
    rd_en = 1'b1; tick; rd_en = 1'b0; tick; tick;
    @(negedge clk_20M);
    check("rd_hold", 32'(rd_data), 32'h0F80);
    tick;

    // second frame with unread bank is dropped; 257th rd_en ignored
    do_reset;
    frame(0, 128); repeat (3) tick;
    check("t2_count_a", 32'(frame_count), 1);
    repeat (5) tick;
    frame(1, 128); repeat (3) tick;
    @(negedge clk_20M);
    check("t2_overrun", 32'(overrun), 1);
    check("t2_count_b", 32'(frame_count), 1);
    check("t2_ready", 32'(frame_ready), 1);
    check("t2_sum", 32'(frame_sum), 32'(SUM0));
    tick;
    read_stream(257, 0, 256);
    check("t2_ready_after_read", 32'(frame_ready), 0);

    // abort after 50 strobes, then a full frame of new data
    do_reset;
    @(negedge clk_20M); check("t3_overrun_cleared", 32'(overrun), 0);
    tick;
    frame(0, 50); repeat (3) tick;
    frame(1, 128); repeat (3) tick;
    @(negedge clk_20M);
    check("t3_overrun", 32'(overrun), 1);
    check("t3_count", 32'(frame_count), 1);
    check("t3_ready", 32'(frame_ready), 1);
    check("t3_sum", 32'(frame_sum), 32'(SUM1));
    tick;
    read_stream(256, 1, 256);

    // reset mid-fill and mid-readout
    do_reset;
    frame(0, 30);
    reset = 1'b1; tick;
    @(negedge clk_20M);
    check_all_zero("t5_fill");
    reset = 1'b0; tick;
    frame(0, 128); repeat (3) tick;
    read_stream(100, 0, 100);
    @(negedge clk_20M);
    check("t5_pre_rd_data", 32'(rd_data), 32'h0FCE);
    check("t5_pre_count", 32'(frame_count), 1);
    reset = 1'b1; tick;
    @(negedge clk_20M);
    check_all_zero("t5_read");
    reset = 1'b0; tick;
    frame(1, 128); repeat (3) tick;
    @(negedge clk_20M);
    check("t5_count", 32'(frame_count), 1);
    check("t5_ready", 32'(frame_ready), 1);
    tick;
    read_stream(256, 1, 256);

    // all-ones frame checksum
    do_reset;
    frame(2, 128); repeat (3) tick;
    @(negedge clk_20M);
    check("t6_sum", 32'(frame_sum), 32'(SUM2));
    check("t6_count", 32'(frame_count), 1);
    tick;
    read_stream(256, 2, 256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
